// File: rtl/move_gate.sv
// rtl/move_gate.sv - direction-permission gate with button auto-repeat and gravity moves
module move_gate #(
  parameter int ROWS      = 4,
  parameter int COLS      = 6,
  parameter int DELAY_CYC = 16,
  parameter int RATE_CYC  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] up_en,
  input  logic [ROWS*COLS-1:0] down_en,
  input  logic [ROWS*COLS-1:0] left_en,
  input  logic [ROWS*COLS-1:0] right_en,
  input  logic [3:0]           btn,
  input  logic                 gravity,
  output logic [3:0]           dir_enable_o,
  output logic                 move_valid,
  output logic [1:0]           move_dir,
  input  logic                 move_ready,
  output logic                 blocked
);

  localparam int MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    DELAY   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t             state_q;
  logic [3:0]         dir_enable_q;
  logic [3:0]         dir_enable_d;
  logic               valid_q;
  logic [1:0]         dir_q;
  logic               blocked_q;
  logic               src_grav_q;
  logic               repeat_q;
  logic               pend_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         btn_dir_d;

  // A direction is permitted only if every cell of the piece permits it
  assign dir_enable_d = {&right_en, &left_en, &down_en, &up_en};

  // Button priority: down > left > right > up
  always_comb begin
    btn_dir_d = DIR_UP;
    if (btn[1])      btn_dir_d = DIR_DOWN;
    else if (btn[2]) btn_dir_d = DIR_LEFT;
    else if (btn[3]) btn_dir_d = DIR_RIGHT;
  end

  // Register the per-direction permission flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_enable_q <= 4'b0000;
    end else begin
      dir_enable_q <= dir_enable_d;
    end
  end

  // Move FSM: gravity/button arbitration, offer handshake and auto-repeat timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      dir_q      <= DIR_UP;
      blocked_q  <= 1'b0;
      src_grav_q <= 1'b0;
      repeat_q   <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      blocked_q <= 1'b0;
      // Gravity outside IDLE is remembered once; extra pulses collapse into it
      if (gravity && (state_q != IDLE)) pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (gravity || pend_q) begin
            pend_q     <= 1'b0;
            dir_q      <= DIR_DOWN;
            src_grav_q <= 1'b1;
            if (dir_enable_q[DIR_DOWN]) begin
              valid_q <= 1'b1;
              state_q <= OFFER;
            end else begin
              blocked_q <= 1'b1;
            end
          end else if (|btn) begin
            dir_q      <= btn_dir_d;
            src_grav_q <= 1'b0;
            if (dir_enable_q[btn_dir_d]) begin
              valid_q <= 1'b1;
              state_q <= OFFER;
            end else begin
              blocked_q <= 1'b1;
              state_q   <= RELEASE;
            end
          end
        end

        OFFER: begin
          if (move_ready) begin
            valid_q <= 1'b0;
            if (src_grav_q) begin
              repeat_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              cnt_q   <= repeat_q ? CNT_W'(RATE_CYC - 1) : CNT_W'(DELAY_CYC - 1);
              state_q <= DELAY;
            end
          end
        end

        DELAY: begin
          if (!btn[dir_q]) begin
            repeat_q <= 1'b0;
            state_q  <= IDLE;
          end else if (cnt_q == '0) begin
            if (dir_enable_q[dir_q]) begin
              valid_q  <= 1'b1;
              repeat_q <= 1'b1;
              state_q  <= OFFER;
            end else begin
              blocked_q <= 1'b1;
              state_q   <= RELEASE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        RELEASE: begin
          if (btn == 4'b0000) begin
            repeat_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign dir_enable_o = dir_enable_q;
  assign move_valid   = valid_q;
  assign move_dir     = dir_q;
  assign blocked      = blocked_q;

endmodule

// File: tb/tb_move_gate.sv
// tb/tb_move_gate.sv - directed self-checking bench for move_gate
module tb_move_gate;

  localparam int ROWS      = 4;
  localparam int COLS      = 6;
  localparam int CELLS     = ROWS * COLS;
  localparam int DELAY_CYC = 16;
  localparam int RATE_CYC  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CELLS-1:0] up_en, down_en, left_en, right_en;
  logic [3:0]       btn;
  logic             gravity;
  logic [3:0]       dir_enable_o;
  logic             move_valid;
  logic [1:0]       move_dir;
  logic             move_ready;
  logic             blocked;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  move_gate #(
    .ROWS(ROWS), .COLS(COLS), .DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .up_en(up_en), .down_en(down_en), .left_en(left_en), .right_en(right_en),
    .btn(btn), .gravity(gravity),
    .dir_enable_o(dir_enable_o),
    .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .blocked(blocked)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs[4];
    int nhs;
    int cyc;
    int cnt;
    logic prev_hs;

    rst = 1'b1;
    up_en = '1; down_en = '1; left_en = '1; right_en = '1;
    btn = 4'b0000; gravity = 1'b0; move_ready = 1'b0;
    tick(); tick();
    chk("rst_dir_en",  32'(dir_enable_o), 32'h0);
    chk("rst_valid",   32'(move_valid),   32'h0);
    chk("rst_dir",     32'(move_dir),     32'h0);
    chk("rst_blocked", 32'(blocked),      32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_dir_en", 32'(dir_enable_o), 32'hF);
    chk("post_rst_valid",  32'(move_valid),   32'h0);

    // Held down button with auto-repeat
    move_ready = 1'b1;
    btn = 4'b0010;
    for (int i = 0; i < 4; i++) hs[i] = 0;
    nhs = 0; cyc = 0; prev_hs = 1'b0;
    while (nhs < 4 && cyc < 120) begin
      tick(); cyc++;
      if (prev_hs) chk("rep_drop_after_hs", 32'(move_valid), 32'h0);
      prev_hs = 1'b0;
      if (move_valid && move_ready) begin
        hs[nhs] = cyc;
        chk("rep_dir", 32'(move_dir), 32'h1);
        nhs++;
        prev_hs = 1'b1;
      end
    end
    chk("rep_count",     32'(nhs),           32'd4);
    chk("rep_first_lat", 32'(hs[0]),         32'd1);
    chk("rep_gap0",      32'(hs[1] - hs[0]), 32'(DELAY_CYC + 1));
    chk("rep_gap1",      32'(hs[2] - hs[1]), 32'(RATE_CYC + 1));
    chk("rep_gap2",      32'(hs[3] - hs[2]), 32'(RATE_CYC + 1));
    btn = 4'b0000;
    tick(); tick(); tick();
    chk("rep_stop", 32'(move_valid), 32'h0);

    // Release the held button at count 3 of the first delay
    btn = 4'b0010;
    tick();
    chk("rel_offer", 32'(move_valid), 32'h1);
    for (int i = 0; i < 13; i++) tick();
    chk("rel_no_early", 32'(move_valid), 32'h0);
    btn = 4'b0000;
    tick();
    chk("rel_idle_valid", 32'(move_valid), 32'h0);
    gravity = 1'b1;
    tick();
    gravity = 1'b0;
    chk("rel_grav_valid", 32'(move_valid), 32'h1);
    chk("rel_grav_dir",   32'(move_dir),   32'h1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (move_valid) cnt++;
    end
    chk("rel_no_more", 32'(cnt), 32'h0);

    // Blocked left move, then RELEASE until buttons drop
    left_en = '1;
    left_en[5] = 1'b0;
    tick();
    chk("blk_dir_en", 32'(dir_enable_o), 32'hB);
    btn = 4'b0100;
    tick();
    chk("blk_pulse", 32'(blocked),    32'h1);
    chk("blk_valid", 32'(move_valid), 32'h0);
    tick();
    chk("blk_pulse_end", 32'(blocked), 32'h0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      gravity = (i == 1);
      tick();
      if (move_valid || blocked) cnt++;
    end
    gravity = 1'b0;
    chk("blk_release_quiet", 32'(cnt), 32'h0);
    btn = 4'b0000;
    tick();
    chk("blk_idle_valid", 32'(move_valid), 32'h0);
    tick();
    chk("blk_pend_valid", 32'(move_valid), 32'h1);
    chk("blk_pend_dir",   32'(move_dir),   32'h1);
    left_en = '1;
    tick();

    // Gravity and right button together: gravity first
    move_ready = 1'b0;
    gravity = 1'b1;
    btn = 4'b1000;
    tick();
    gravity = 1'b0;
    chk("pri_grav_valid", 32'(move_valid), 32'h1);
    chk("pri_grav_dir",   32'(move_dir),   32'h1);
    move_ready = 1'b1;
    tick();
    chk("pri_gap", 32'(move_valid), 32'h0);
    tick();
    chk("pri_right_valid", 32'(move_valid), 32'h1);
    chk("pri_right_dir",   32'(move_dir),   32'h3);
    btn = 4'b0000;
    tick(); tick();
    chk("pri_done", 32'(move_valid), 32'h0);

    // Stalled offer with gravity pulses and an enable change
    move_ready = 1'b0;
    gravity = 1'b1;
    tick();
    gravity = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold", 32'({move_valid, move_dir}), 32'h5);
      if (i == 5) chk("stall_en_changed", 32'(dir_enable_o), 32'hD);
      gravity = (i == 2) || (i == 5);
      if (i == 3) down_en[7] = 1'b0;
      if (i == 6) down_en = '1;
      if (i == 9) move_ready = 1'b1;
      tick();
    end
    gravity = 1'b0;
    chk("stall_after_hs", 32'(move_valid), 32'h0);
    tick();
    chk("stall_extra_valid", 32'(move_valid), 32'h1);
    chk("stall_extra_dir",   32'(move_dir),   32'h1);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (move_valid) cnt++;
    end
    chk("stall_only_one", 32'(cnt), 32'h0);

    // Asynchronous reset during an offer
    move_ready = 1'b0;
    gravity = 1'b1;
    tick();
    chk("ar_valid_before", 32'(move_valid), 32'h1);
    tick();
    gravity = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid",   32'(move_valid),   32'h0);
    chk("ar_dir",     32'(move_dir),     32'h0);
    chk("ar_dir_en",  32'(dir_enable_o), 32'h0);
    chk("ar_blocked", 32'(blocked),      32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_dir_en_back", 32'(dir_enable_o), 32'hF);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (move_valid) cnt++;
      tick();
    end
    chk("ar_pend_cleared", 32'(cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_gate.md
MOVE_GATE -- requirements
Module: move_gate

Interface
REQ-001 Parameter ROWS, default 4, number of piece rows per direction grid.
REQ-002 Parameter COLS, default 6, number of piece columns per direction grid; CELLS = ROWS*COLS.
REQ-003 Parameter DELAY_CYC, default 16, hold cycles before the first auto-repeat; legal range >= 1.
REQ-004 Parameter RATE_CYC, default 4, cycles between later auto-repeats; legal range >= 1.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 up_en  in  CELLS  per-cell up-move permission; bit r+ROWS*c is cell [r][c].
REQ-008 down_en  in  CELLS  per-cell down-move permission; same indexing.
REQ-009 left_en  in  CELLS  per-cell left-move permission; same indexing.
REQ-010 right_en  in  CELLS  per-cell right-move permission; same indexing.
REQ-011 btn  in  4  synchronised, debounced button levels; bit0 up, bit1 down, bit2 left, bit3 right.
REQ-012 gravity  in  1  single-cycle pulse requesting a forced down move.
REQ-013 dir_enable_o  out  4  registered all-cells-permit flag per direction; same bit order as btn.
REQ-014 move_valid  out  1  move offer valid.
REQ-015 move_dir  out  2  offered direction: 0 up, 1 down, 2 left, 3 right.
REQ-016 move_ready  in  1  consumer accepts the offer.
REQ-017 blocked  out  1  one-cycle pulse: requested move refused.

Function
REQ-018 dir_enable_o[d] SHALL be the AND-reduction of all CELLS bits of direction d, registered, latency 1 cycle.
REQ-019 Button selection SHALL use priority down > left > right > up among asserted btn bits.
REQ-020 FSM states SHALL be IDLE, OFFER, DELAY, RELEASE.
REQ-021 IDLE: a gravity pulse or a pending gravity SHALL take precedence over buttons; source = gravity, dir = down.
REQ-022 IDLE with a request: if dir_enable_o[dir] = 1, go to OFFER; else pulse blocked and go to IDLE (gravity) or RELEASE (button).
REQ-023 OFFER: move_valid = 1, and move_dir SHALL hold stable until the cycle where move_valid and move_ready are both 1.
REQ-024 After an OFFER handshake, gravity source SHALL go to IDLE; button source SHALL go to DELAY, loading the counter with DELAY_CYC-1 (first press) or RATE_CYC-1 (repeat).
REQ-025 move_valid SHALL drop in the cycle after the handshake; a dir_enable_o change during OFFER SHALL NOT retract the offer.
REQ-026 DELAY: the counter decrements each cycle. If the held button bit deasserts, go to IDLE. At count 0 with the button held, re-check dir_enable_o[dir]: enabled goes to OFFER with the repeat flag set; blocked pulses blocked and goes to RELEASE.
REQ-027 In DELAY and OFFER, other button presses SHALL be ignored; the held direction SHALL NOT change.
REQ-028 A gravity pulse arriving outside IDLE SHALL set a single pending bit, served on the next IDLE cycle; further pulses while pending SHALL be dropped.
REQ-029 RELEASE: stay until btn = 0, then go to IDLE; the repeat flag SHALL clear on entry to IDLE.
REQ-030 Counter width SHALL be $clog2(max(DELAY_CYC,RATE_CYC)+1); it SHALL not wrap below 0.

Reset
REQ-031 rst = 1 SHALL asynchronously force state IDLE, and clear the counter, the pending bit and the repeat flag.
REQ-032 While rst = 1, dir_enable_o = 0, move_valid = 0, move_dir = 0, and blocked = 0.
REQ-033 rst asserted mid-OFFER SHALL drop move_valid immediately, with no handshake counted.

Verification
REQ-034 All enables 1, btn = 4'b0010 held, move_ready = 1 -> handshakes at T, T+DELAY_CYC+1, then every RATE_CYC+1 cycles, each with move_dir = 1.
REQ-035 left_en bit 5 = 0, btn = 4'b0100 -> one blocked pulse, move_valid stays 0, FSM in RELEASE until btn = 0.
REQ-036 gravity pulse and btn = 4'b1000 in the same IDLE cycle -> offer move_dir = 1 first; the right move is offered after its own evaluation.
REQ-037 move_ready = 0 for 10 cycles in OFFER, with two gravity pulses -> move_valid and move_dir stable; exactly one extra down offer after the handshake.
REQ-038 btn released in DELAY at count 3 -> no further offer; IDLE next cycle.
REQ-039 rst asserted while move_valid = 1 -> all outputs 0 in the same cycle; after release, dir_enable_o is valid 1 cycle later.
